mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch (IF) read port and a memory-access (MA)
// read/write port share one synchronous single-port RAM. MA normally has priority, but
// after MAX_CONSEC contested MA wins the IF port is forced through to avoid starvation.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,

    // Instruction-fetch read port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    // Memory-access read/write port
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_gnt,
    output logic              ma_rvalid,
    output logic [DATA_W-1:0] ma_rdata,

    // Memory side
    output logic              clka,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,

    output logic              busy
);

    // Wide enough to hold 0..MAX_CONSEC; at least one bit even for MAX_CONSEC == 0.
    localparam int unsigned CNT_W = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic {
        OwnerIf,
        OwnerMa
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ena_q, ena_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;

    logic              if_gnt_q, if_gnt_d;
    logic              ma_gnt_q, ma_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ma_rvalid_q, ma_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;

    logic              cnt_sat;
    logic              ma_win;
    logic              if_win;

    // Arbitration decision; only acted upon in StIdle.
    always_comb begin
        cnt_sat = (cnt_q == CNT_W'(MAX_CONSEC));
        // MA wins whenever it asks, except when IF is also waiting and has been
        // passed over MAX_CONSEC times in a row.
        ma_win  = ma_req && !(if_req && cnt_sat);
        if_win  = if_req && !ma_win;
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ena_d       = 1'b0;
        wea_d       = 1'b0;
        addra_d     = addra_q;
        dina_d      = dina_q;
        if_gnt_d    = 1'b0;
        ma_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ma_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;

        case (state_q)
            StIdle: begin
                if (ma_win) begin
                    state_d  = StIssue;
                    owner_d  = OwnerMa;
                    ena_d    = 1'b1;
                    wea_d    = ma_we;
                    addra_d  = ma_addr;
                    dina_d   = ma_wdata;
                    ma_gnt_d = 1'b1;
                    // Only a contested win counts towards the starvation limit.
                    cnt_d    = if_req ? cnt_q + CNT_W'(1) : '0;
                end else if (if_win) begin
                    state_d  = StIssue;
                    owner_d  = OwnerIf;
                    ena_d    = 1'b1;
                    wea_d    = 1'b0;
                    addra_d  = if_addr;
                    if_gnt_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            StIssue: begin
                // Writes finish here; reads wait one cycle for douta.
                state_d = wea_q ? StIdle : StWait;
            end

            StWait: begin
                state_d = StIdle;
                if (owner_q == OwnerMa) begin
                    ma_rvalid_d = 1'b1;
                    ma_rdata_d  = douta;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = douta;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            cnt_q       <= '0;
            ena_q       <= 1'b0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            if_gnt_q    <= 1'b0;
            ma_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ma_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ena_q       <= ena_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            if_gnt_q    <= if_gnt_d;
            ma_gnt_q    <= ma_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ma_rvalid_q <= ma_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
        end
    end

    assign clka      = clk;
    assign ena       = ena_q;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign if_gnt    = if_gnt_q;
    assign ma_gnt    = ma_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ma_rvalid = ma_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ma_rdata  = ma_rdata_q;
    assign busy      = (state_q != StIdle);

    // Grants are mutually exclusive and the starvation counter stays in range.
    a_gnt_excl: assert property (@(posedge clk) disable iff (!rst) !(if_gnt_q && ma_gnt_q));
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst) cnt_q <= CNT_W'(MAX_CONSEC));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, every cycle checked
// against a transaction-level model (free-at time, pending read, consecutive-win count).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_CONSEC = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic              ma_gnt;
    logic              ma_rvalid;
    logic [DATA_W-1:0] ma_rdata;
    logic              clka;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_CONSEC(MAX_CONSEC)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ma_req   (ma_req),
        .ma_we    (ma_we),
        .ma_addr  (ma_addr),
        .ma_wdata (ma_wdata),
        .ma_gnt   (ma_gnt),
        .ma_rvalid(ma_rvalid),
        .ma_rdata (ma_rdata),
        .clka     (clka),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .douta    (douta),
        .busy     (busy)
    );

    // Power-on contents of the memory, shared by the device and the reference model.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(5)) return 32'hDEADBEEF;
        return 32'h9E3779B9 * (DATA_W'(a) + 32'd1);
    endfunction

    // Synchronous single-port RAM; unwritten words read as their power-on value.
    logic [DATA_W-1:0] dev_mem [DEPTH];
    bit   [DEPTH-1:0]  dev_written;
    always @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                dev_mem[addra]     <= dina;
                dev_written[addra] <= 1'b1;
            end else begin
                douta <= dev_written[addra] ? dev_mem[addra] : init_word(addra);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    longint            edge_no;
    longint            free_at;     // first edge at which a new request can be accepted
    longint            rd_due;      // edge at which a pending read returns, -1 if none
    bit                rd_for_ma;
    logic [DATA_W-1:0] rd_val;
    int                streak;      // MA wins in a row while IF was also waiting
    bit                e_if_gnt, e_ma_gnt, e_if_rv, e_ma_rv, e_ena, e_wea, e_busy;
    logic [ADDR_W-1:0] e_addra;
    logic [DATA_W-1:0] e_dina, e_if_rdata, e_ma_rdata;

    task automatic model_step();
        bit ma_wins;
        e_if_gnt = 1'b0;
        e_ma_gnt = 1'b0;
        e_if_rv  = 1'b0;
        e_ma_rv  = 1'b0;
        e_ena    = 1'b0;
        e_wea    = 1'b0;
        if (!rst) begin
            streak     = 0;
            rd_due     = -1;
            free_at    = edge_no + 1;
            e_if_rdata = '0;
            e_ma_rdata = '0;
            e_busy     = 1'b0;
        end else begin
            if (rd_due == edge_no) begin
                if (rd_for_ma) begin
                    e_ma_rv    = 1'b1;
                    e_ma_rdata = rd_val;
                end else begin
                    e_if_rv    = 1'b1;
                    e_if_rdata = rd_val;
                end
                rd_due = -1;
            end
            if (edge_no >= free_at && (if_req || ma_req)) begin
                ma_wins = ma_req && !(if_req && streak == int'(MAX_CONSEC));
                e_ena   = 1'b1;
                if (ma_wins) begin
                    streak   = if_req ? streak + 1 : 0;
                    e_ma_gnt = 1'b1;
                    e_wea    = ma_we;
                    e_addra  = ma_addr;
                    if (ma_we) begin
                        e_dina           = ma_wdata;
                        ref_mem[ma_addr] = ma_wdata;
                        free_at          = edge_no + 2;
                    end else begin
                        rd_due    = edge_no + 2;
                        rd_for_ma = 1'b1;
                        rd_val    = ref_mem[ma_addr];
                        free_at   = edge_no + 3;
                    end
                end else begin
                    streak    = 0;
                    e_if_gnt  = 1'b1;
                    e_addra   = if_addr;
                    rd_due    = edge_no + 2;
                    rd_for_ma = 1'b0;
                    rd_val    = ref_mem[if_addr];
                    free_at   = edge_no + 3;
                end
            end
            e_busy = (edge_no + 1 < free_at);
        end
        edge_no++;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
        check_eq("ma_gnt", 64'(ma_gnt), 64'(e_ma_gnt));
        check_eq("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
        check_eq("ma_rvalid", 64'(ma_rvalid), 64'(e_ma_rv));
        check_eq("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
        check_eq("ma_rdata", 64'(ma_rdata), 64'(e_ma_rdata));
        check_eq("ena", 64'(ena), 64'(e_ena));
        check_eq("wea", 64'(wea), 64'(e_wea));
        check_eq("busy", 64'(busy), 64'(e_busy));
        check_eq("gnt_excl", 64'(if_gnt & ma_gnt), 64'd0);
        if (e_ena) check_eq("addra", 64'(addra), 64'(e_addra));
        if (e_ena && e_wea) check_eq("dina", 64'(dina), 64'(e_dina));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Advance until the selected grant appears; n is the number of edges taken.
    task automatic wait_gnt(input bit for_ma, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(for_ma ? ma_gnt : if_gnt) && n < 20);
        check_eq("gnt_timeout", 64'(for_ma ? ma_gnt : if_gnt), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ngr;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(ADDR_W'(i));
        edge_no    = 0;
        free_at    = 0;
        rd_due     = -1;
        rd_for_ma  = 1'b0;
        rd_val     = '0;
        streak     = 0;
        e_addra    = '0;
        e_dina     = '0;
        e_if_rdata = '0;
        e_ma_rdata = '0;

        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0;
        repeat (3) cycle();
        check_eq("rst_ena", 64'(ena), 64'd0);
        check_eq("rst_addra", 64'(addra), 64'd0);
        check_eq("rst_dina", 64'(dina), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);

        // IF alone reads 0x05; first arbitration at the first edge with rst high.
        rst = 1'b1; if_req = 1'b1; if_addr = 7'h05;
        wait_gnt(1'b0, n);
        check_eq("if_gnt_lat", 64'(n), 64'd1);
        check_eq("if_addra", 64'(addra), 64'h05);
        check_eq("if_ena", 64'(ena), 64'd1);
        check_eq("if_wea", 64'(wea), 64'd0);
        if_req = 1'b0;
        cycle();
        check_eq("if_rv_early", 64'(if_rvalid), 64'd0);
        cycle();
        check_eq("if_rv", 64'(if_rvalid), 64'd1);
        check_eq("if_data", 64'(if_rdata), 64'hDEADBEEF);

        // MA write then read back; inputs changed after the grant must not matter.
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 7'h10; ma_wdata = 32'h12345678;
        wait_gnt(1'b1, n);
        check_eq("wr_ena", 64'(ena), 64'd1);
        check_eq("wr_wea", 64'(wea), 64'd1);
        check_eq("wr_addra", 64'(addra), 64'h10);
        check_eq("wr_dina", 64'(dina), 64'h12345678);
        ma_wdata = 32'hBAD0BAD0; ma_addr = 7'h11;
        ma_we = 1'b0; ma_addr = 7'h10;
        wait_gnt(1'b1, n);
        check_eq("wr_rate", 64'(n), 64'd2);
        ma_req = 1'b0; ma_we = 1'b1; ma_addr = 7'h3F;
        cycle();
        cycle();
        check_eq("ma_rv", 64'(ma_rvalid), 64'd1);
        check_eq("ma_data", 64'(ma_rdata), 64'h12345678);

        // Simultaneous requests: MA read goes first, IF at the next idle.
        if_req = 1'b1; if_addr = 7'h05;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 7'h10;
        wait_gnt(1'b1, n);
        check_eq("both_ma_first", 64'(n), 64'd1);
        check_eq("both_if_waits", 64'(if_gnt), 64'd0);
        ma_req = 1'b0;
        wait_gnt(1'b0, n);
        check_eq("if_after_rd", 64'(n), 64'd3);
        if_req = 1'b0;
        cycle();
        cycle();

        // Both held high: MA,MA,MA,MA,IF repeating.
        if_req = 1'b1; if_addr = 7'h07;
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 7'h20; ma_wdata = DATA_W'($urandom);
        ngr = 0;
        for (int c = 0; c < 80 && ngr < 10; c++) begin
            cycle();
            if (if_gnt || ma_gnt) begin
                check_eq("seq_if", 64'(if_gnt), 64'((ngr % 5) == 4));
                ngr++;
                if (ma_gnt) ma_wdata = DATA_W'($urandom);
            end
        end
        check_eq("seq_count", 64'(ngr), 64'd10);
        if_req = 1'b0; ma_req = 1'b0;
        repeat (4) cycle();

        // Reset while waiting for read data aborts the read.
        if_req = 1'b1; if_addr = 7'h05;
        wait_gnt(1'b0, n);
        if_req = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("abort_rv", 64'(if_rvalid), 64'd0);
        check_eq("abort_ena", 64'(ena), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_rdata", 64'(if_rdata), 64'd0);
        check_eq("abort_madata", 64'(ma_rdata), 64'd0);
        rst = 1'b1; if_req = 1'b1; if_addr = 7'h05;
        wait_gnt(1'b0, n);
        check_eq("post_rst_lat", 64'(n), 64'd1);
        if_req = 1'b0;
        cycle();
        cycle();
        check_eq("post_rst_rv", 64'(if_rvalid), 64'd1);
        check_eq("post_rst_data", 64'(if_rdata), 64'hDEADBEEF);

        // Random traffic with occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) != 0);
            cycle();
            if (e_if_gnt) if_req = 1'b0;
            if (e_ma_gnt) begin
                ma_req   = 1'b0;
                ma_we    = 1'($urandom);
                ma_addr  = ADDR_W'($urandom);
                ma_wdata = DATA_W'($urandom);
            end
            if (!if_req) begin
                if ($urandom_range(0, 99) < 50) begin
                    if_req  = 1'b1;
                    if_addr = ADDR_W'($urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                if_req = 1'b0;
            end
            if (!ma_req) begin
                if ($urandom_range(0, 99) < 50) begin
                    ma_req   = 1'b1;
                    ma_we    = 1'($urandom);
                    ma_addr  = ADDR_W'($urandom_range(0, 15));
                    ma_wdata = DATA_W'($urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                ma_req = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
